// File: rtl/scan_rw_ctrl.sv
// Request sequencer between the static register front-end and mem_reg_mux.
// Turns one qualified request into a one-cycle scan strobe, with optional write readback and timeout.
module scan_rw_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              static_wen,
    input  logic              static_ren,
    input  logic              static_verify,
    input  logic [ADDR_W-1:0] static_addr,
    input  logic [DATA_W-1:0] static_wdata,
    output logic              static_ready,
    output logic              static_busy,
    output logic              static_err,
    output logic              static_mismatch,
    output logic [DATA_W-1:0] static_rdata,
    output logic              scan_wen,
    output logic              scan_ren,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_wdata,
    input  logic [DATA_W-1:0] scan_rdata,
    input  logic              scan_ready
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] VISSUE = 3'd3;
    localparam logic [2:0] VWAIT  = 3'd4;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              req_wr_q, req_wr_d;
    logic              req_verify_q, req_verify_d;

    logic              static_ready_q, static_ready_d;
    logic              static_busy_q, static_busy_d;
    logic              static_err_q, static_err_d;
    logic              static_mismatch_q, static_mismatch_d;
    logic [DATA_W-1:0] static_rdata_q, static_rdata_d;

    logic              scan_wen_q, scan_wen_d;
    logic              scan_ren_q, scan_ren_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic [DATA_W-1:0] scan_wdata_q, scan_wdata_d;

    logic              timed_out;

    // The wait counter covers every cycle of an access that ends without scan_ready,
    // including the strobe cycle itself, so TIMEOUT cycles of silence abort the access.
    assign timed_out = !scan_ready && (cnt_q == CNT_LAST);

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        req_addr_d        = req_addr_q;
        req_wdata_d       = req_wdata_q;
        req_wr_d          = req_wr_q;
        req_verify_d      = req_verify_q;
        static_ready_d    = static_ready_q;
        static_err_d      = static_err_q;
        static_mismatch_d = static_mismatch_q;
        static_rdata_d    = static_rdata_q;

        case (state_q)
            IDLE: begin
                if (id_valid && (static_wen || static_ren)) begin
                    state_d           = ISSUE;
                    cnt_d             = '0;
                    req_addr_d        = static_addr;
                    req_wdata_d       = static_wdata;
                    req_wr_d          = static_wen;
                    req_verify_d      = static_wen && static_verify;
                    static_ready_d    = 1'b0;
                    static_err_d      = 1'b0;
                    static_mismatch_d = 1'b0;
                end
            end

            ISSUE, WAIT: begin
                if (scan_ready) begin
                    cnt_d = '0;
                    if (!req_wr_q) begin
                        static_rdata_d = scan_rdata;
                        static_ready_d = 1'b1;
                        state_d        = IDLE;
                    end else if (req_verify_q) begin
                        state_d = VISSUE;
                    end else begin
                        static_ready_d = 1'b1;
                        state_d        = IDLE;
                    end
                end else if (timed_out) begin
                    cnt_d          = '0;
                    static_err_d   = 1'b1;
                    static_ready_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = WAIT;
                end
            end

            VISSUE, VWAIT: begin
                if (scan_ready) begin
                    cnt_d             = '0;
                    static_rdata_d    = scan_rdata;
                    static_mismatch_d = (scan_rdata != req_wdata_q);
                    static_ready_d    = 1'b1;
                    state_d           = IDLE;
                end else if (timed_out) begin
                    cnt_d          = '0;
                    static_err_d   = 1'b1;
                    static_ready_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = VWAIT;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Scan outputs are decoded from the next state so the strobe is registered
    // and lines up exactly with the ISSUE/VISSUE cycle.
    always_comb begin
        scan_wen_d    = (state_d == ISSUE) && req_wr_d;
        scan_ren_d    = ((state_d == ISSUE) && !req_wr_d) || (state_d == VISSUE);
        scan_addr_d   = '0;
        scan_wdata_d  = '0;
        static_busy_d = (state_d != IDLE);
        if (state_d == ISSUE) begin
            scan_addr_d  = req_addr_d;
            scan_wdata_d = req_wdata_d;
        end else if (state_d == VISSUE) begin
            scan_addr_d = req_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            req_addr_q        <= '0;
            req_wdata_q       <= '0;
            req_wr_q          <= 1'b0;
            req_verify_q      <= 1'b0;
            static_ready_q    <= 1'b0;
            static_busy_q     <= 1'b0;
            static_err_q      <= 1'b0;
            static_mismatch_q <= 1'b0;
            static_rdata_q    <= '0;
            scan_wen_q        <= 1'b0;
            scan_ren_q        <= 1'b0;
            scan_addr_q       <= '0;
            scan_wdata_q      <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            req_addr_q        <= req_addr_d;
            req_wdata_q       <= req_wdata_d;
            req_wr_q          <= req_wr_d;
            req_verify_q      <= req_verify_d;
            static_ready_q    <= static_ready_d;
            static_busy_q     <= static_busy_d;
            static_err_q      <= static_err_d;
            static_mismatch_q <= static_mismatch_d;
            static_rdata_q    <= static_rdata_d;
            scan_wen_q        <= scan_wen_d;
            scan_ren_q        <= scan_ren_d;
            scan_addr_q       <= scan_addr_d;
            scan_wdata_q      <= scan_wdata_d;
        end
    end

    assign static_ready    = static_ready_q;
    assign static_busy     = static_busy_q;
    assign static_err      = static_err_q;
    assign static_mismatch = static_mismatch_q;
    assign static_rdata    = static_rdata_q;
    assign scan_wen        = scan_wen_q;
    assign scan_ren        = scan_ren_q;
    assign scan_addr       = scan_addr_q;
    assign scan_wdata      = scan_wdata_q;

endmodule

// File: tb/tb_scan_rw_ctrl.sv
// Self-checking bench for scan_rw_ctrl: a behavioural mem_reg_mux target with
// programmable response delay plus a transaction-level model of the expected results.
module tb_scan_rw_ctrl;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic          static_wen;
    logic          static_ren;
    logic          static_verify;
    logic [AW-1:0] static_addr;
    logic [DW-1:0] static_wdata;
    logic          static_ready;
    logic          static_busy;
    logic          static_err;
    logic          static_mismatch;
    logic [DW-1:0] static_rdata;
    logic          scan_wen;
    logic          scan_ren;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] scan_wdata;
    logic [DW-1:0] scan_rdata;
    logic          scan_ready;

    int checks = 0;
    int errors = 0;

    // target bookkeeping, one transaction at a time
    int            tgt_nw, tgt_nr, tgt_idx, tgt_d1, tgt_d2, idle_bad;
    logic [DW-1:0] tgt_data;
    logic [AW-1:0] w_addr, r_addr;
    logic [DW-1:0] w_data, r_wdata;

    logic [DW-1:0] model_rdata;

    scan_rw_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .static_wen     (static_wen),
        .static_ren     (static_ren),
        .static_verify  (static_verify),
        .static_addr    (static_addr),
        .static_wdata   (static_wdata),
        .static_ready   (static_ready),
        .static_busy    (static_busy),
        .static_err     (static_err),
        .static_mismatch(static_mismatch),
        .static_rdata   (static_rdata),
        .scan_wen       (scan_wen),
        .scan_ren       (scan_ren),
        .scan_addr      (scan_addr),
        .scan_wdata     (scan_wdata),
        .scan_rdata     (scan_rdata),
        .scan_ready     (scan_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Target: answers each strobe with scan_ready after the programmed delay
    // (0 = same cycle as the strobe, negative = never); first strobe uses d1, later ones d2.
    initial begin
        int cur_d;
        int wcnt;
        bit pending;
        scan_ready = 1'b0;
        scan_rdata = '0;
        pending    = 1'b0;
        wcnt       = 0;
        cur_d      = 0;
        forever begin
            @(negedge clk);
            scan_rdata = $urandom;
            scan_ready = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (scan_wen || scan_ren) begin
                    if (scan_wen) begin
                        tgt_nw++;
                        w_addr = scan_addr;
                        w_data = scan_wdata;
                    end
                    if (scan_ren) begin
                        tgt_nr++;
                        r_addr  = scan_addr;
                        r_wdata = scan_wdata;
                    end
                    cur_d   = (tgt_idx == 0) ? tgt_d1 : tgt_d2;
                    tgt_idx++;
                    pending = 1'b1;
                    wcnt    = 0;
                end else if (scan_addr != '0 || scan_wdata != '0) begin
                    idle_bad++;
                end
                if (pending) begin
                    if (cur_d >= 0 && wcnt == cur_d) begin
                        scan_ready = 1'b1;
                        scan_rdata = tgt_data;
                        pending    = 1'b0;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level expectations: what the requester should see given the
    // target's response delays and data. Latency is counted from the accept cycle
    // to the first cycle static_ready is visible; -1 means not checked.
    task automatic modelTxn(input logic wen, input logic ren, input logic ver,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] tdata,
                            input int d1, input int d2,
                            output logic e_err, output logic e_mis, output logic [DW-1:0] e_rd,
                            output int e_lat, output int e_nw, output int e_nr);
        bit is_wr;
        bit vfy;
        is_wr = wen;
        vfy   = wen && ver;
        e_err = 1'b0;
        e_mis = 1'b0;
        e_rd  = model_rdata;
        e_nw  = is_wr ? 1 : 0;
        e_nr  = (!is_wr && ren) ? 1 : 0;
        e_lat = -1;
        if (d1 < 0 || d1 >= TO) begin
            e_err = 1'b1;
            e_lat = 1 + TO;
        end else if (!is_wr) begin
            e_rd  = tdata;
            e_lat = 2 + d1;
        end else if (!vfy) begin
            e_lat = 2 + d1;
        end else begin
            e_nr = 1;
            if (d2 < 0 || d2 >= TO) begin
                e_err = 1'b1;
            end else begin
                e_rd  = tdata;
                e_mis = (tdata != wdata);
            end
        end
    endtask

    task automatic applyStimulus(input logic wen, input logic ren, input logic ver,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [DW-1:0] tdata, input int d1, input int d2,
                                 input bit pokes);
        logic          e_err, e_mis;
        logic [DW-1:0] e_rd;
        int            e_lat, e_nw, e_nr;
        int            lat;
        int            busy_bad;
        bit            seen;
        modelTxn(wen, ren, ver, wdata, tdata, d1, d2, e_err, e_mis, e_rd, e_lat, e_nw, e_nr);
        tgt_d1        = d1;
        tgt_d2        = d2;
        tgt_data      = tdata;
        tgt_nw        = 0;
        tgt_nr        = 0;
        tgt_idx       = 0;
        static_wen    = wen;
        static_ren    = ren;
        static_verify = ver;
        static_addr   = addr;
        static_wdata  = wdata;
        id_valid      = 1'b1;
        lat           = 0;
        busy_bad      = 0;
        seen          = 1'b0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            id_valid = 1'b0;
            if (static_ready) begin
                seen = 1'b1;
            end else begin
                if (!static_busy) busy_bad++;
                if (pokes) id_valid = 1'($urandom % 2);
            end
        end
        static_wen    = 1'b0;
        static_ren    = 1'b0;
        static_verify = 1'b0;
        id_valid      = 1'b0;
        checkOutput("completed_in_bound", 64'(seen), 64'd1);
        if (e_lat >= 0) checkOutput("latency", 64'(lat), 64'(e_lat));
        checkOutput("static_err", 64'(static_err), 64'(e_err));
        checkOutput("static_mismatch", 64'(static_mismatch), 64'(e_mis));
        checkOutput("static_rdata", 64'(static_rdata), 64'(e_rd));
        checkOutput("busy_at_ready", 64'(static_busy), 64'd0);
        checkOutput("busy_while_active", 64'(busy_bad), 64'd0);
        checkOutput("scan_wen_pulses", 64'(tgt_nw), 64'(e_nw));
        checkOutput("scan_ren_pulses", 64'(tgt_nr), 64'(e_nr));
        if (e_nw > 0) begin
            checkOutput("write_addr", 64'(w_addr), 64'(addr));
            checkOutput("write_data", 64'(w_data), 64'(wdata));
        end
        if (e_nr > 0) checkOutput("read_addr", 64'(r_addr), 64'(addr));
        if (e_nw > 0 && e_nr > 0) checkOutput("readback_wdata", 64'(r_wdata), 64'd0);
        model_rdata = e_rd;
    endtask

    initial begin
        rst_n         = 1'b0;
        id_valid      = 1'b0;
        static_wen    = 1'b0;
        static_ren    = 1'b0;
        static_verify = 1'b0;
        static_addr   = '0;
        static_wdata  = '0;
        tgt_nw        = 0;
        tgt_nr        = 0;
        tgt_idx       = 0;
        tgt_d1        = 0;
        tgt_d2        = 0;
        idle_bad      = 0;
        tgt_data      = '0;
        w_addr        = '0;
        r_addr        = '0;
        w_data        = '0;
        r_wdata       = '0;
        model_rdata   = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 64'(static_ready), 64'd0);
        checkOutput("rst_busy", 64'(static_busy), 64'd0);
        checkOutput("rst_err", 64'(static_err), 64'd0);
        checkOutput("rst_mismatch", 64'(static_mismatch), 64'd0);
        checkOutput("rst_rdata", 64'(static_rdata), 64'd0);
        checkOutput("rst_scan_wen", 64'(scan_wen), 64'd0);
        checkOutput("rst_scan_ren", 64'(scan_ren), 64'd0);
        checkOutput("rst_scan_addr", 64'(scan_addr), 64'd0);
        checkOutput("rst_scan_wdata", 64'(scan_wdata), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] read with 3-cycle target");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0012, 32'h0, 32'hDEADBEEF, 3, 0, 1'b0);

        $display("[TB] verified writes, mismatching then matching readback");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0040, 32'h0000A5A5, 32'h0000A5A4, 1, 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0040, 32'h0000A5A5, 32'h0000A5A5, 0, 0, 1'b0);

        $display("[TB] read timeout");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0044, 32'h0, 32'h11111111, -1, 0, 1'b0);

        $display("[TB] zero-wait targets with id_valid pokes while busy");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0100, 32'h0, 32'hCAFEF00D, 0, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0104, 32'h01234567, 32'h0, 0, 0, 1'b1);

        $display("[TB] wen and ren together, verify on read, readback timeout");
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0200, 32'h89ABCDEF, 32'h55555555, 2, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0204, 32'h0, 32'h76543210, 1, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0208, 32'h0F0F0F0F, 32'h0F0F0F0F, 1, -1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h020C, 32'h0, 32'h22222222, TO - 1, 0, 1'b0);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 24; i++) begin
            logic          rw, rr, rv;
            logic [AW-1:0] ra;
            logic [DW-1:0] rwd, rtd;
            int            rd1, rd2;
            rw  = 1'($urandom % 2);
            rr  = rw ? 1'($urandom % 2) : 1'b1;
            rv  = 1'($urandom % 2);
            ra  = 16'($urandom);
            rwd = $urandom;
            rtd = ($urandom % 2 == 0) ? rwd : $urandom;
            rd1 = int'($urandom_range(10, 0)) - 1;
            rd2 = int'($urandom_range(5, 0)) - 1;
            applyStimulus(rw, rr, rv, ra, rwd, rtd, rd1, rd2, 1'b1);
        end

        $display("[TB] reset during WAIT");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0300, 32'h0, 32'h12345678, 1, 0, 1'b0);
        tgt_d1        = -1;
        tgt_idx       = 0;
        static_ren    = 1'b1;
        static_addr   = 16'h0304;
        id_valid      = 1'b1;
        @(negedge clk);
        id_valid      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy_before_reset", 64'(static_busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 64'(static_busy), 64'd0);
        checkOutput("mid_rst_ready", 64'(static_ready), 64'd0);
        checkOutput("mid_rst_rdata", 64'(static_rdata), 64'd0);
        checkOutput("mid_rst_scan_ren", 64'(scan_ren), 64'd0);
        checkOutput("mid_rst_scan_addr", 64'(scan_addr), 64'd0);
        static_ren = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        tgt_nw = 0;
        tgt_nr = 0;
        repeat (10) @(negedge clk);
        checkOutput("post_rst_pulses", 64'(tgt_nw + tgt_nr), 64'd0);
        checkOutput("post_rst_busy", 64'(static_busy), 64'd0);
        checkOutput("post_rst_ready", 64'(static_ready), 64'd0);
        model_rdata = '0;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0308, 32'h0, 32'hA0B0C0D0, 0, 0, 1'b0);

        checkOutput("idle_scan_zero", 64'(idle_bad), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
